// File: rtl/io_reg_deser.sv
// ----------------------------------------------------------------------------
// io_reg_deser
//
// Receiving end of the scrambled 512:1 I/O register test mux. A framed
// single-bit stream is reassembled into a WIDTH-bit word. Bit n of a frame
// lands at par_out[n ^ key], where key is the 3-bit common select captured
// on the frame-start bit and zero-extended to IDX_W bits. A completed word
// is held on a valid/ready handshake. Valid bits that arrive while the word
// is still unconsumed are dropped and raise a sticky overrun flag.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   ser_in       serial data bit
//   ser_valid    ser_in is valid this cycle
//   frame_start  first bit of a frame (qualified by ser_valid)
//   com_sel      index scramble key, sampled on an accepted frame start
//   par_out      assembled word (registered)
//   par_valid    par_out holds a complete frame (registered)
//   par_ready    downstream accepts par_out
//   busy         state is not IDLE (registered)
//   overrun      sticky: a valid bit was dropped while holding a word
// ----------------------------------------------------------------------------
module io_reg_deser #(
    parameter int WIDTH = 512,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    input  logic [2:0]       com_sel,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   count_q,     count_d;
    logic [IDX_W-1:0]   key_q,       key_d;
    logic [WIDTH-1:0]   par_out_q,   par_out_d;
    logic               par_valid_q, par_valid_d;
    logic               overrun_q,   overrun_d;
    logic               busy_q,      busy_d;

    logic [IDX_W-1:0]   com_sel_ext;
    logic               start;
    logic               handshake;

    // The 3-bit key only ever perturbs the low index bits.
    assign com_sel_ext = {{(IDX_W-3){1'b0}}, com_sel};
    assign start       = ser_valid && frame_start;
    // par_valid_q is only ever high in HOLD, so par_ready outside HOLD
    // cannot complete a handshake.
    assign handshake   = par_valid_q && par_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal takes its held value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        key_d       = key_q;
        par_out_d   = par_out_q;
        par_valid_d = par_valid_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                // A lone ser_valid without frame_start is simply ignored.
                if (start) begin
                    state_d         = ST_COLLECT;
                    par_out_d       = '0;
                    par_out_d[com_sel_ext] = ser_in;
                    key_d           = com_sel_ext;
                    count_d         = ONE_IDX;
                    overrun_d       = 1'b0;
                end
            end

            ST_COLLECT: begin
                if (start) begin
                    // Resynchronise: partial word is thrown away.
                    state_d         = ST_COLLECT;
                    par_out_d       = '0;
                    par_out_d[com_sel_ext] = ser_in;
                    key_d           = com_sel_ext;
                    count_d         = ONE_IDX;
                    overrun_d       = 1'b0;
                end else if (ser_valid) begin
                    par_out_d[count_q ^ key_q] = ser_in;
                    // Wraps to zero naturally after the last bit.
                    count_d = count_q + ONE_IDX;
                    if (count_q == LAST_IDX) begin
                        state_d     = ST_HOLD;
                        par_valid_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (handshake) begin
                    par_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    // Zero-bubble restart on the consuming edge.
                    if (start) begin
                        state_d         = ST_COLLECT;
                        par_out_d       = '0;
                        par_out_d[com_sel_ext] = ser_in;
                        key_d           = com_sel_ext;
                        count_d         = ONE_IDX;
                        overrun_d       = 1'b0;
                    end
                end else if (ser_valid) begin
                    // Word still owned by downstream: the bit is lost,
                    // frame_start or not.
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy is registered from the next state so it has no input path.
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: par_out is reset like the control state because its reset value
    // is architecturally visible; it is a register bank, not a RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            key_q       <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            count_q     <= count_d;
            key_q       <= key_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_io_reg_deser.sv
// ----------------------------------------------------------------------------
// tb_io_reg_deser
//
// Directed bench for io_reg_deser with WIDTH = 512. Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point, well away from
// the next active edge.
// ----------------------------------------------------------------------------
module tb_io_reg_deser;

    localparam int WIDTH = 512;
    localparam int IDX_W = 9;

    logic             clk;
    logic             reset_n;
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic [2:0]       com_sel;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ready;
    logic             busy;
    logic             overrun;

    int n_checks;
    int n_fail;

    io_reg_deser #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .com_sel     (com_sel),
        .par_out     (par_out),
        .par_valid   (par_valid),
        .par_ready   (par_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives nbits stream bits (frame_start on bit 0). Reports the 1-based
    // edge at which par_valid was first seen high and whether busy ever
    // dropped during the frame.
    task automatic send_bits(input logic [WIDTH-1:0] bits,
                             input logic [2:0] sel0,
                             input logic [2:0] sel_rest,
                             input int nbits,
                             output int rise_edge,
                             output bit busy_drop);
        rise_edge = 0;
        busy_drop = 1'b0;
        for (int n = 0; n < nbits; n++) begin
            ser_valid   = 1'b1;
            frame_start = (n == 0);
            ser_in      = bits[n];
            com_sel     = (n == 0) ? sel0 : sel_rest;
            tick();
            if (par_valid && rise_edge == 0) rise_edge = n + 1;
            if (!busy) busy_drop = 1'b1;
        end
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        ser_in      = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        ser_in      = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        com_sel     = 3'd0;
        par_ready   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (par_out !== '0 || par_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: par_out=%h par_valid=%b busy=%b overrun=%b, want all 0",
                     par_out, par_valid, busy, overrun);
        end
    endtask

    task automatic test_sel0();
        logic [WIDTH-1:0] bits;
        logic [WIDTH-1:0] exp;
        int  rise;
        bit  bdrop;
        bits = '0; bits[5] = 1'b1;
        exp  = '0; exp[5]  = 1'b1;
        par_ready = 1'b0;
        send_bits(bits, 3'd0, 3'd0, WIDTH, rise, bdrop);
        n_checks++;
        if (rise !== 512) begin
            n_fail++;
            $display("FAIL sel0_latency: par_valid rose at edge %0d, want 512", rise);
        end
        n_checks++;
        if (bdrop !== 1'b0) begin
            n_fail++;
            $display("FAIL sel0_busy: busy dropped during frame, want busy=1 throughout");
        end
        n_checks++;
        if (par_out !== exp) begin
            n_fail++;
            $display("FAIL sel0_word: par_out=%h want %h", par_out, exp);
        end
        // No ready yet: the word must hold.
        tick();
        n_checks++;
        if (par_valid !== 1'b1 || par_out !== exp) begin
            n_fail++;
            $display("FAIL sel0_hold: par_valid=%b par_out=%h want 1 / %h", par_valid, par_out, exp);
        end
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
        n_checks++;
        if (par_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sel0_handshake: par_valid=%b busy=%b want 0 0", par_valid, busy);
        end
    endtask

    // Key 5 moves stream bit 5 to index 0; com_sel changes after the first
    // bit to show the key is latched at frame start.
    task automatic test_scramble();
        logic [WIDTH-1:0] bits;
        logic [WIDTH-1:0] exp;
        int  rise;
        bit  bdrop;
        bits = '0; bits[5] = 1'b1;
        exp  = '0; exp[0]  = 1'b1;
        send_bits(bits, 3'b101, 3'b010, WIDTH, rise, bdrop);
        n_checks++;
        if (par_out !== exp || rise !== 512) begin
            n_fail++;
            $display("FAIL scramble_word: par_out=%h rise=%0d want %h rise=512", par_out, rise, exp);
        end
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
    endtask

    // ser_valid toggles every cycle; invalid cycles carry ser_in=0 so any
    // stray write would clear a bit of the all-ones word.
    task automatic test_gapped();
        int rise;
        logic [WIDTH-1:0] exp;
        exp  = '1;
        rise = 0;
        for (int c = 0; c < 2 * WIDTH; c++) begin
            ser_valid   = (c % 2 == 0);
            frame_start = (c == 0);
            ser_in      = (c % 2 == 0);
            com_sel     = 3'b011;
            tick();
            if (par_valid && rise == 0) rise = c + 1;
        end
        ser_valid = 1'b0; frame_start = 1'b0; ser_in = 1'b0;
        n_checks++;
        if (rise !== 1023) begin
            n_fail++;
            $display("FAIL gapped_latency: par_valid rose at cycle %0d, want 1023", rise);
        end
        n_checks++;
        if (par_out !== exp || par_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gapped_word: par_out=%h par_valid=%b want all ones / 1", par_out, par_valid);
        end
    endtask

    // Starts in HOLD with the all-ones word from test_gapped.
    task automatic test_overrun();
        logic [WIDTH-1:0] exp;
        exp = '1;
        par_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ser_valid   = 1'b1;
            frame_start = (i == 2);
            ser_in      = 1'b0;
            com_sel     = 3'd7;
            tick();
            if (i == 0) begin
                n_checks++;
                if (overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_first: overrun=%b want 1", overrun);
                end
            end
        end
        ser_valid = 1'b0; frame_start = 1'b0;
        n_checks++;
        if (par_out !== exp || par_valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_hold: par_out=%h par_valid=%b overrun=%b busy=%b want ones/1/1/1",
                     par_out, par_valid, overrun, busy);
        end
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
        n_checks++;
        if (par_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: par_valid=%b busy=%b overrun=%b want 0 0 1",
                     par_valid, busy, overrun);
        end
        // Valid bit without frame start in IDLE is ignored.
        ser_valid = 1'b1; ser_in = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b1 || par_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: busy=%b overrun=%b par_valid=%b want 0 1 0",
                     busy, overrun, par_valid);
        end
        frame_start = 1'b1; com_sel = 3'd0;
        tick();
        ser_valid = 1'b0; frame_start = 1'b0; ser_in = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_clear: overrun=%b busy=%b want 0 1", overrun, busy);
        end
    endtask

    // Enters in COLLECT (from test_overrun); frame A therefore also
    // exercises a resync. par_ready stays 1, frame B starts on A's
    // handshake edge.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] a_bits;
        logic [WIDTH-1:0] b_bits;
        logic [WIDTH-1:0] b_exp;
        int  rise;
        bit  bdrop;
        a_bits = {256{2'b10}};
        b_bits = '0; b_bits[1] = 1'b1;
        b_exp  = '0; b_exp[6]  = 1'b1;   // 1 ^ 7 = 6
        par_ready = 1'b1;
        send_bits(a_bits, 3'd0, 3'd0, WIDTH, rise, bdrop);
        n_checks++;
        if (par_out !== a_bits || rise !== 512 || bdrop !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: par_out=%h rise=%0d busy_drop=%b want alt/512/0",
                     par_out, rise, bdrop);
        end
        send_bits(b_bits, 3'd7, 3'd7, WIDTH, rise, bdrop);
        n_checks++;
        if (rise !== 512 || bdrop !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble: rise=%0d busy_drop=%b want 512 0", rise, bdrop);
        end
        n_checks++;
        if (par_out !== b_exp || par_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: par_out=%h par_valid=%b want %h 1", par_out, par_valid, b_exp);
        end
        tick();
        par_ready = 1'b0;
        n_checks++;
        if (par_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: par_valid=%b busy=%b want 0 0", par_valid, busy);
        end
    endtask

    task automatic test_resync();
        logic [WIDTH-1:0] bits;
        logic [WIDTH-1:0] exp;
        int  rise;
        bit  bdrop;
        par_ready = 1'b0;
        send_bits('1, 3'd2, 3'd2, 200, rise, bdrop);
        n_checks++;
        if (rise !== 0) begin
            n_fail++;
            $display("FAIL resync_partial: par_valid at edge %0d, want none", rise);
        end
        bits = '0; bits[9] = 1'b1;
        exp  = '0; exp[9]  = 1'b1;
        send_bits(bits, 3'd0, 3'd0, WIDTH, rise, bdrop);
        n_checks++;
        if (par_out !== exp || rise !== 512) begin
            n_fail++;
            $display("FAIL resync_word: par_out=%h rise=%0d want %h 512", par_out, rise, exp);
        end
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  rise;
        bit  bdrop;
        bit  bad;
        send_bits('1, 3'd3, 3'd3, 300, rise, bdrop);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (par_out !== '0 || par_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: par_out=%h par_valid=%b busy=%b overrun=%b want all 0",
                     par_out, par_valid, busy, overrun);
        end
        tick();
        reset_n = 1'b1;
        // Remaining bits of the aborted frame must be ignored.
        bad = 1'b0;
        for (int i = 0; i < 600; i++) begin
            ser_valid = 1'b1; frame_start = 1'b0; ser_in = 1'b1;
            tick();
            if (par_valid || busy || par_out != '0) bad = 1'b1;
        end
        ser_valid = 1'b0; ser_in = 1'b0;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_valid: activity after mid-frame reset, want none");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sel0();
        test_scramble();
        test_gapped();
        test_overrun();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_reg_deser.md
# io_reg_deser

Serial-to-parallel reassembly block for the I/O register test path: the receiving end of the 512:1 scrambled mux selection. It collects a framed single-bit stream into a WIDTH-bit word, using the same 3-bit common-select XOR scrambling of the bit index. It presents the word on a valid/ready handshake and flags bits that arrive while a completed word is still unconsumed. It sits between the mux output register and downstream pad-facing logic.

## Interface
- WIDTH, 512, word length in bits; must be a power of two, at least 8.
- IDX_W, 9, index width, equal to log2(WIDTH).

- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is valid this cycle.
- frame_start  input  1  marks the first bit of a frame; only meaningful with ser_valid.
- com_sel  input  3  index scramble key, zero-extended to IDX_W; sampled at frame start.
- par_out  output  WIDTH  assembled word.
- par_valid  output  1  par_out holds a complete frame.
- par_ready  input  1  downstream accepts par_out.
- busy  output  1  high whenever state is not IDLE.
- overrun  output  1  sticky: a valid bit was dropped in HOLD.

## Operation
- Registers:
  - state (IDLE/COLLECT/HOLD)
  - count, IDX_W bits
  - key, IDX_W bits
  - par_out
  - overrun
- Bit n of a frame (n = 0..WIDTH-1) is written to par_out[n ^ key]; the index XOR is modulo 2^IDX_W and always in range.
- Frame-start acceptance, when ser_valid && frame_start in a cycle where it is honoured:
  - par_out cleared, then bit 0 written at [0 ^ com_sel].
  - key <= com_sel; count <= 1; overrun <= 0.
  - Next state: COLLECT.
- IDLE:
  - Frame start accepted per the rule above.
  - ser_valid without frame_start is ignored; no flag is set.
- COLLECT:
  - Each ser_valid writes par_out[count ^ key] <= ser_in and increments count.
  - When the written bit is n = WIDTH-1: count wraps to 0, state goes to HOLD, par_valid <= 1.
  - ser_valid && frame_start in COLLECT resynchronises: partial data is discarded and the frame restarts exactly as a frame-start acceptance.
  - Cycles without ser_valid hold all state.
- HOLD:
  - par_out is stable and par_valid is high until par_valid && par_ready.
  - On handshake: par_valid <= 0 and state goes to IDLE.
  - If ser_valid && frame_start arrive in the handshake cycle, the frame start is accepted at the same edge (zero bubble). State goes to COLLECT, not IDLE.
  - ser_valid without a completing handshake drops the bit and sets overrun. This applies whether or not frame_start is high.
- Reset values:
  - state = IDLE, count = 0, key = 0.
  - par_out = 0, par_valid = 0, busy = 0, overrun = 0.
- Reset mid-frame discards all partial data immediately; no par_valid follows.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Latency: the last bit is sampled at edge E; par_valid is high from just after E.
  - Minimum frame is WIDTH consecutive ser_valid cycles. par_valid rises WIDTH edges after the frame-start edge, counting that edge as the first.
- Handshake: par_ready is sampled only while par_valid = 1.
  - par_valid falls on the edge where par_valid && par_ready.
  - par_ready while not in HOLD has no effect.
- busy rises on the frame-start edge. It falls on the handshake edge, unless a new frame is accepted on that same edge.
- overrun asserts on the edge after the offending ser_valid. It clears only on reset or on the next accepted frame start.
- Back-to-back frames with par_ready held at 1: throughput is one word per WIDTH cycles, with no idle cycle required.

## Test plan
- Reset, then a frame with com_sel=0 and ser_in = (n==5): par_out = 1<<5; par_valid rises 512 cycles after the frame start; busy = 1 throughout.
- Same stream with com_sel=3'b101: bit 5 lands at index 0, so par_out = 1.
- Gapped stream, with ser_valid toggling 1/0 for 1024 cycles and the all-ones pattern: par_valid after the 512th valid bit; par_out is all ones.
- Hold par_ready=0 for 3 cycles after par_valid, with ser_valid=1 in each: par_out unchanged; overrun=1 from the first of these; it clears on the next frame start.
- par_ready=1 together with ser_valid && frame_start in the handshake cycle: no bubble; busy stays 1; second word correct.
- Frame start at bit 200, and separately reset_n low at bit 300: restart gives a full fresh 512-bit frame; reset gives all outputs 0 and no par_valid.
